// File: rtl/divu_if.sv
// Start/busy/done bus for the sequential unsigned divider.
//
// Handshake: the master raises start with dividend/divisor valid; the slave
// samples them on the rising edge only while idle or done (start is ignored
// while busy). busy is high for every RUN cycle. done is a one-cycle pulse,
// and quotient/remainder/div_zero are valid in that cycle and held until the
// next accepted start. busy and done are never high together.
//
// Ports (modports):
//   master : drives start, dividend, divisor; observes results
//   slave  : observes start, dividend, divisor; drives results
interface divu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/divu_seq_32.sv
// Multi-cycle unsigned divider using restoring division, one quotient bit
// per clock. A divide by zero skips the iteration and reports all-ones
// quotient, remainder = dividend and div_zero.
//
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   bus       : divu_if slave (start/dividend/divisor in, busy/done/results out)
//   state_dbg : current FSM state (0 IDLE, 1 RUN, 2 DONE)
module divu_seq_32 #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  divu_if.slave      bus,
  output logic [1:0] state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] q;   // dividend shifts out the top, quotient bits in the bottom
  logic [WIDTH-1:0] r;   // partial remainder
  logic [WIDTH-1:0] d;   // latched divisor
  logic [CW-1:0]    cnt;
  logic             dz;

  logic [WIDTH:0] t;
  logic [WIDTH:0] diff;
  logic           borrow;

  // One restoring step: bring the next dividend bit into the remainder and
  // try subtracting the divisor; a borrow means the trial failed.
  always_comb begin
    t      = {r, q[WIDTH-1]};
    diff   = t - {1'b0, d};
    borrow = diff[WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) next_state = (bus.divisor == '0) ? S_DONE : S_RUN;
        else           next_state = S_IDLE;
      end
      S_RUN: begin
        if (cnt == '0) next_state = S_DONE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      r   <= '0;
      d   <= '0;
      cnt <= '0;
      dz  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              q  <= '1;
              r  <= bus.dividend;
              dz <= 1'b1;
            end else begin
              q   <= bus.dividend;
              d   <= bus.divisor;
              r   <= '0;
              cnt <= CNT_INIT;
              dz  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          r <= borrow ? t[WIDTH-1:0] : diff[WIDTH-1:0];
          q <= {q[WIDTH-2:0], ~borrow};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state == S_RUN);
  assign bus.done      = (state == S_DONE);
  assign bus.quotient  = q;
  assign bus.remainder = r;
  assign bus.div_zero  = dz;
  assign state_dbg     = state;

endmodule
